// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - byte handshake and status bundle between uart_rx and its consumer
interface uart_rx_if;
  logic [7:0] uart_dat_o;
  logic       uart_valid_o;
  logic       uart_rd_i;
  logic       uart_busy;
  logic       uart_frame_err_o;
  logic       uart_overrun_o;

  modport master (
    output uart_dat_o,
    output uart_valid_o,
    output uart_busy,
    output uart_frame_err_o,
    output uart_overrun_o,
    input  uart_rd_i
  );

  modport slave (
    input  uart_dat_o,
    input  uart_valid_o,
    input  uart_busy,
    input  uart_frame_err_o,
    input  uart_overrun_o,
    output uart_rd_i
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with majority sampling and a byte buffer
// Define UART_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module uart_rx #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic      sys_clk_i,
  input  logic      sys_rst_i,
  input  logic      uart_rx_i,
  uart_rx_if.master bus
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx: FIFO_DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [2:0]    s_q;
  logic          m;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          ferr_q, ferr_d;
  logic          push;
  logic          overrun_q;

  // The line is asynchronous; two flops settle it before the majority window sees it.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      s_q     <= 3'b111;
    end else begin
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
      s_q     <= {s_q[1:0], sync2_q};
    end
  end

  assign m = (s_q[0] & s_q[1]) | (s_q[0] & s_q[2]) | (s_q[1] & s_q[2]);

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!s_q[0]) state_d = S_START;
      end
      S_START: begin
        // A start bit still low at mid-period is genuine; anything else was noise.
        if (cnt_q == HALF) begin
          if (m) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == LAST) begin
          sh_d  = {m, sh_q[7:1]};
          cnt_d = '0;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (m) push = 1'b1;
          else   ferr_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full, pop, wr;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = bus.uart_rd_i & ~empty;
  // When full, a same-cycle pop frees the very slot the push overwrites.
  assign wr    = push & (~full | pop);

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && full && !pop) overrun_q <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (wr) mem_q[wr_ptr_q[AW-1:0]] <= sh_q;
  end

  assign bus.uart_valid_o = ~empty;
  assign bus.uart_dat_o   = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
`else
  logic [7:0] dat_q;
  logic       valid_q;
  logic       pop;

  assign pop = bus.uart_rd_i & valid_q;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      dat_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (push && (!valid_q || pop)) begin
        dat_q   <= sh_q;
        valid_q <= 1'b1;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
      if (push && valid_q && !pop) overrun_q <= 1'b1;
    end
  end

  assign bus.uart_valid_o = valid_q;
  assign bus.uart_dat_o   = dat_q;
`endif

  assign bus.uart_busy        = (state_q != S_IDLE);
  assign bus.uart_frame_err_o = ferr_q;
  assign bus.uart_overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed vector bench for uart_rx
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   ferr_cnt = 0;
  int   busy_cnt = 0;
  int   fb, bb;

  uart_rx_if bus();

  uart_rx dut (
    .sys_clk_i(clk),
    .sys_rst_i(rst),
    .uart_rx_i(rx),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.uart_frame_err_o === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (bus.uart_busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  typedef struct {
    logic [7:0] data;
    int         per;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_dat;
    int         exp_ferr;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int per, input logic stop);
    rx = 1'b0;
    wait_cyc(per);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(per);
    end
    rx = stop;
    wait_cyc(per);
    rx = 1'b1;
  endtask

  task automatic read_byte();
    bus.uart_rd_i = 1'b1;
    wait_cyc(1);
    bus.uart_rd_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 104, 1'b1, 1'b1, 8'hA5, 0};
    vecs[1] = '{8'h3C, 104, 1'b0, 1'b0, 8'h00, 1};
    vecs[2] = '{8'h55, 104, 1'b1, 1'b1, 8'h55, 0};
    vecs[3] = '{8'hC3, 101, 1'b1, 1'b1, 8'hC3, 0};
    vecs[4] = '{8'h0F, 101, 1'b1, 1'b1, 8'h0F, 0};
    vecs[5] = '{8'h96, 107, 1'b1, 1'b1, 8'h96, 0};
    vecs[6] = '{8'hE1, 107, 1'b1, 1'b1, 8'hE1, 0};
    vecs[7] = '{8'h00, 104, 1'b1, 1'b1, 8'h00, 0};
    vecs[8] = '{8'hFF, 104, 1'b1, 1'b1, 8'hFF, 0};

    bus.uart_rd_i = 1'b0;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(5);
    @(negedge clk);
    chk("reset_valid", bus.uart_valid_o, 0);
    chk("reset_dat", bus.uart_dat_o, 0);
    chk("reset_busy", bus.uart_busy, 0);
    chk("reset_ferr", bus.uart_frame_err_o, 0);
    chk("reset_overrun", bus.uart_overrun_o, 0);

    for (int i = 0; i < NV; i++) begin
      fb = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].per, vecs[i].stop);
      wait_cyc(4);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), bus.uart_valid_o, vecs[i].exp_valid);
      chk($sformatf("vec%0d_ferr_cycles", i), ferr_cnt - fb, vecs[i].exp_ferr);
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_dat", i), bus.uart_dat_o, vecs[i].exp_dat);
        read_byte();
        @(negedge clk);
        chk($sformatf("vec%0d_valid_after_rd", i), bus.uart_valid_o, 0);
      end
      wait_cyc(100);
      @(negedge clk);
      chk($sformatf("vec%0d_busy_idle", i), bus.uart_busy, 0);
      chk($sformatf("vec%0d_overrun", i), bus.uart_overrun_o, 0);
    end

    fb = ferr_cnt;
    bb = busy_cnt;
    rx = 1'b0;
    wait_cyc(30);
    rx = 1'b1;
    wait_cyc(100);
    @(negedge clk);
    chk("glitch_busy_seen", (busy_cnt > bb) ? 1 : 0, 1);
    chk("glitch_busy_idle", bus.uart_busy, 0);
    chk("glitch_valid", bus.uart_valid_o, 0);
    chk("glitch_ferr", ferr_cnt - fb, 0);

`ifdef UART_RX_FIFO_EN
    for (int i = 0; i < 17; i++) send_frame(8'(i), 104, 1'b1);
    wait_cyc(20);
    @(negedge clk);
    chk("fifo_overrun", bus.uart_overrun_o, 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fifo_valid%0d", i), bus.uart_valid_o, 1);
      chk($sformatf("fifo_dat%0d", i), bus.uart_dat_o, i);
      read_byte();
      @(negedge clk);
    end
    chk("fifo_empty", bus.uart_valid_o, 0);
`else
    send_frame(8'h11, 104, 1'b1);
    @(negedge clk);
    chk("ovr_first_overrun", bus.uart_overrun_o, 0);
    send_frame(8'h22, 104, 1'b1);
    wait_cyc(20);
    @(negedge clk);
    chk("ovr_valid", bus.uart_valid_o, 1);
    chk("ovr_dat", bus.uart_dat_o, 8'h11);
    chk("ovr_overrun", bus.uart_overrun_o, 1);
`endif

    fb = ferr_cnt;
    rx = 1'b0;
    wait_cyc(104);
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 0) ? 1'b1 : 1'b0;
      wait_cyc(104);
    end
    rx = 1'b1;
    wait_cyc(50);
    @(negedge clk);
    chk("rst_pre_busy", bus.uart_busy, 1);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", bus.uart_valid_o, 0);
    chk("rst_dat", bus.uart_dat_o, 0);
    chk("rst_busy", bus.uart_busy, 0);
    chk("rst_ferr", bus.uart_frame_err_o, 0);
    chk("rst_overrun", bus.uart_overrun_o, 0);
    wait_cyc(1200);
    @(negedge clk);
    chk("rst_settle_valid", bus.uart_valid_o, 0);
    chk("rst_settle_ferr", ferr_cnt - fb, 0);
    send_frame(8'h7E, 104, 1'b1);
    wait_cyc(20);
    @(negedge clk);
    chk("post_rst_valid", bus.uart_valid_o, 1);
    chk("post_rst_dat", bus.uart_dat_o, 8'h7E);
    chk("post_rst_ferr", ferr_cnt - fb, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8N1 by default, LSB first. It is the host-to-FPGA counterpart of the existing `uart` transmitter and runs on the same 12 MHz system clock. The block turns the host's serial line into bytes for the capture-control logic, such as frame-send requests and register pokes. It synchronises the line, validates the start bit, majority-samples each bit at mid-period and presents bytes through a valid/read handshake with overrun and framing-error reporting.

## Interface
- `CLK_HZ`, 12000000, system clock frequency.
- `BAUD`, 115200, line rate; bit period `DIV = (CLK_HZ + BAUD/2) / BAUD`, which is 104 at defaults.
- `FIFO_DEPTH`, 16, receive FIFO entries (power of two, at least 2); used only when `UART_RX_FIFO_EN` is defined.

Ports:
- `sys_clk_i`, in, 1, system clock.
- `sys_rst_i`, in, 1, reset, synchronous active-high.
- `uart_rx_i`, in, 1, serial line, asynchronous, idle high.
- `uart_dat_o`, out, 8, received byte at the head of the buffer.
- `uart_valid_o`, out, 1, `uart_dat_o` holds an unread byte.
- `uart_rd_i`, in, 1, consume head byte; ignored while `uart_valid_o` is 0.
- `uart_busy`, out, 1, a frame is being received (state is not IDLE).
- `uart_frame_err_o`, out, 1, one-cycle pulse when the stop bit is sampled low.
- `uart_overrun_o`, out, 1, sticky; set when a byte is dropped because the buffer is full; cleared only by reset.

## Operation
- **Input synchroniser.** `uart_rx_i` passes through a 2-flop synchroniser, reset to 1, followed by a 3-bit shift register `s[2:0]`. The majority of `s` is the sampled bit `m`.
- **Counters.** Bit-period counter `cnt` is `$clog2(DIV)` bits wide. Bit index `idx` is 3 bits. Shift register `sh` is 8 bits.
- **State machine:**
  - IDLE: when the synchronised line is 0 (falling edge seen), set `cnt = 0` and go to START.
  - START: when `cnt == DIV/2`, check `m`. If `m == 1`, it was a glitch; return to IDLE with no flags. If `m == 0`, set `cnt = 0` and `idx = 0` and go to DATA.
  - DATA: when `cnt == DIV-1`, set `sh = {m, sh[7:1]}`, reset `cnt`, and increment `idx`. After `idx == 7`, go to STOP.
  - STOP: when `cnt == DIV-1`, sample `m`.
    - If `m == 1`, push `sh` into the buffer.
    - If `m == 0`, pulse `uart_frame_err_o` and discard the byte.
    - Then go to IDLE. IDLE re-arms immediately, so a start bit that directly follows a stop bit is caught.
- **Buffer (no FIFO).** A single holding register.
  - A push sets `uart_valid_o`.
  - `uart_rd_i && uart_valid_o` clears it.
  - A push while valid and not being read in the same cycle drops the new byte, keeps the old one, and sets `uart_overrun_o`.
  - A push and a read in the same cycle loads the new byte and keeps valid at 1.
- **Reset values:** state IDLE; `uart_dat_o = 0`; `uart_valid_o`, `uart_busy`, `uart_frame_err_o`, `uart_overrun_o` all 0. Reset asserted mid-frame aborts the frame and discards the partial byte.

## Timing
- From the falling edge at the pin to START takes 3 cycles (2 synchroniser flops plus the edge register).
- The start bit is checked `DIV/2` cycles after entering START. Each data bit is then sampled one full `DIV` later, which lands at the majority-window centre.
- `uart_valid_o` rises 1 cycle after the STOP sample. `uart_dat_o` is stable while valid is high.
- Reads take effect on the clock edge; `uart_valid_o` falls in the next cycle if the buffer is empty.
- `uart_frame_err_o` is high for exactly 1 cycle, aligned with the cycle in which the push would have occurred.
- Tolerated baud mismatch: at least ±3% at defaults.

## Configuration
- **`UART_RX_FIFO_EN` defined:** the holding register is replaced by a `FIFO_DEPTH`-entry FIFO with registered read and write pointers, each one bit wider than `$clog2(FIFO_DEPTH)`.
  - `uart_valid_o` means the FIFO is not empty.
  - `uart_dat_o` is the head entry, shown first-word-fall-through.
  - Full is when the pointers differ only in the MSB. A push when full and not being read drops the byte and sets overrun.
  - A simultaneous push and pop when full is accepted.
  - Pointers wrap naturally.
- **Not defined:** single holding register as described under Operation; `FIFO_DEPTH` is unused.

## Test plan
- Reset, then send 0xA5 at 115200 (104 cycles per bit) -> `uart_valid_o` is 1 and `uart_dat_o` is 0xA5; `uart_rd_i` clears valid the next cycle; no error flags.
- 30-cycle low glitch on an idle line -> returns to IDLE; `uart_valid_o` stays 0 and `uart_frame_err_o` stays 0.
- Send 0x3C with the stop bit forced low -> one-cycle `uart_frame_err_o` pulse; `uart_valid_o` stays 0; the next frame 0x55 is received correctly.
- Send 0x11 then 0x22 back-to-back without reading (no FIFO) -> `uart_dat_o` is 0x11 and `uart_overrun_o` is 1. With `UART_RX_FIFO_EN`: send 17 bytes 0x00..0x10 with no reads -> first 16 are read out in order, 0x10 is lost, overrun is 1.
- Bit period stretched to 101 cycles and then to 107 cycles, random bytes -> all bytes received error-free.
- Assert `sys_rst_i` for 1 cycle during bit 4 of a frame -> all outputs return to 0; the following clean frame 0x7E is received correctly.
